// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: write-back source selects,
// write-back stage state encoding and the register-write qualifier.
package cpu_pkg;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PCS  = 2'd2;

    localparam int LOAD_TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        WB_IDLE      = 2'd0,
        WB_LOAD_WAIT = 2'd1,
        WB_HALTED    = 2'd2
    } wb_state_e;

    // R0 is hard-wired to zero when zero_ro is set, so its writes are dropped.
    function automatic logic wb_write_en(input logic       we,
                                         input logic [3:0] rd,
                                         input logic       zero_ro);
        return we && !(zero_ro && (rd == 4'd0));
    endfunction

endpackage

// File: rtl/wb_load_timer.sv
// Load wait counter: cleared outside a load, counts cycles without data and
// flags the last allowed wait cycle.
module wb_load_timer #(
    parameter int LIMIT = 15,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_r;

    // Wait-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST_CNT);

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires MEM-stage instructions into the register file,
// waits for multi-cycle loads (with timeout) and latches HLT.
module wb_stage
    import cpu_pkg::*;
#(
    parameter int LOAD_TIMEOUT = LOAD_TIMEOUT_DEF,
    parameter bit ZERO_REG_RO  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_reg_write,
    input  logic [3:0]  mem_rd,
    input  logic [1:0]  mem_wb_sel,
    input  logic [15:0] mem_alu_result,
    input  logic [15:0] mem_pc_plus2,
    input  logic        mem_halt,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_rvalid,
    output logic [3:0]  DstReg,
    output logic        WriteReg,
    output logic [15:0] DstData,
    output logic        wb_stall,
    output logic        halt_out,
    output logic        load_err,
    output logic [15:0] retired_count
);

    wb_state_e   state_r;
    wb_state_e   state_next_s;
    logic        accept_s;
    logic        load_accept_s;
    logic        expired_s;
    logic        timer_clr_s;
    logic        timer_en_s;
    logic        write_s;
    logic        retire_s;
    logic        set_err_s;
    logic [3:0]  dst_reg_s;
    logic [15:0] dst_data_s;
    logic [3:0]  ld_rd_r;
    logic        ld_we_r;

    assign accept_s      = mem_valid && !wb_stall && (state_r != WB_HALTED);
    assign load_accept_s = accept_s && !mem_halt && (mem_wb_sel == WB_LOAD);

    wb_load_timer #(
        .LIMIT (LOAD_TIMEOUT),
        .CNT_W (8)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr_s),
        .en      (timer_en_s),
        .expired (expired_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= WB_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            WB_IDLE: begin
                if (accept_s && mem_halt) begin
                    state_next_s = WB_HALTED;
                end else if (load_accept_s) begin
                    state_next_s = WB_LOAD_WAIT;
                end else begin
                    state_next_s = WB_IDLE;
                end
            end
            WB_LOAD_WAIT: begin
                if (dmem_rvalid || expired_s) begin
                    state_next_s = WB_IDLE;
                end else begin
                    state_next_s = WB_LOAD_WAIT;
                end
            end
            WB_HALTED: state_next_s = WB_HALTED;
            default:   state_next_s = WB_IDLE;
        endcase
    end

    // Next values for the register-file port, retire/error strobes and timer control.
    always_comb begin
        write_s     = 1'b0;
        retire_s    = 1'b0;
        set_err_s   = 1'b0;
        timer_clr_s = 1'b1;
        timer_en_s  = 1'b0;
        dst_reg_s   = DstReg;
        dst_data_s  = DstData;
        case (state_r)
            WB_IDLE: begin
                if (accept_s && !mem_halt && (mem_wb_sel != WB_LOAD)) begin
                    retire_s = 1'b1;
                    write_s  = wb_write_en(mem_reg_write, mem_rd, ZERO_REG_RO);
                    if (write_s) begin
                        dst_reg_s  = mem_rd;
                        dst_data_s = (mem_wb_sel == WB_PCS) ? mem_pc_plus2 : mem_alu_result;
                    end else begin
                        dst_reg_s  = DstReg;
                        dst_data_s = DstData;
                    end
                end else if (accept_s && mem_halt) begin
                    retire_s = 1'b1;
                end else begin
                    retire_s = 1'b0;
                end
            end
            WB_LOAD_WAIT: begin
                timer_clr_s = 1'b0;
                // Data on the expiry edge still completes the load.
                if (dmem_rvalid) begin
                    retire_s = 1'b1;
                    write_s  = wb_write_en(ld_we_r, ld_rd_r, ZERO_REG_RO);
                    if (write_s) begin
                        dst_reg_s  = ld_rd_r;
                        dst_data_s = dmem_rdata;
                    end else begin
                        dst_reg_s  = DstReg;
                        dst_data_s = DstData;
                    end
                end else if (expired_s) begin
                    set_err_s = 1'b1;
                end else begin
                    timer_en_s = 1'b1;
                end
            end
            WB_HALTED: begin
                retire_s = 1'b0;
            end
            default: begin
                retire_s = 1'b0;
            end
        endcase
    end

    // Output and load-context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            DstReg        <= 4'd0;
            WriteReg      <= 1'b0;
            DstData       <= 16'd0;
            wb_stall      <= 1'b0;
            halt_out      <= 1'b0;
            load_err      <= 1'b0;
            retired_count <= 16'd0;
            ld_rd_r       <= 4'd0;
            ld_we_r       <= 1'b0;
        end else begin
            DstReg        <= dst_reg_s;
            WriteReg      <= write_s;
            DstData       <= dst_data_s;
            wb_stall      <= (state_next_s != WB_IDLE);
            halt_out      <= halt_out || (state_next_s == WB_HALTED);
            load_err      <= load_err || set_err_s;
            retired_count <= retired_count + {15'd0, retire_s};
            if (load_accept_s) begin
                ld_rd_r <= mem_rd;
                ld_we_r <= mem_reg_write;
            end else begin
                ld_rd_r <= ld_rd_r;
                ld_we_r <= ld_we_r;
            end
        end
    end

endmodule
